// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU operation encodings and the control bundle for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  // ALUOp encodings carried from decode to EX
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  // A bubble is an instruction with every control bit cleared
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and PC / IF-ID write enables.
module id_ex_stage_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              mem_read_ex_i,
  input  logic              valid_ex_i,
  input  logic [REG_AW-1:0] rt_ex_i,
  input  logic              valid_id_i,
  input  logic [REG_AW-1:0] rs_id_i,
  input  logic [REG_AW-1:0] rt_id_i,
  input  logic              uses_rt_id_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              lu_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
);

  // A load in EX whose destination (never $0) feeds a source of the ID instruction
  always_comb begin
    lu_o = mem_read_ex_i & valid_ex_i & (rt_ex_i != '0) & valid_id_i &
           ((rt_ex_i == rs_id_i) | (uses_rt_id_i & (rt_ex_i == rt_id_i)));
    // A flush discards the dependent instruction, so the front end need not stall for it
    pc_write_o   = ~hold_i & ~(lu_o & ~flush_i);
    ifid_write_o = pc_write_o;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter.
// Update priority per edge: reset, hold (freeze), flush (bubble), load-use (bubble + count), load.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              uses_rt_id,
  input  logic [DATA_W-1:0] rdata1_id,
  input  logic [DATA_W-1:0] rdata2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic              RegWrite_id,
  input  logic              MemRead_id,
  input  logic              MemWrite_id,
  input  logic              MemtoReg_id,
  input  logic              ALUSrc_id,
  input  logic              RegDst_id,
  input  logic [3:0]        ALUOp_id,
  output logic              valid_ex,
  output logic [REG_AW-1:0] rs_ex,
  output logic [REG_AW-1:0] rt_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic [DATA_W-1:0] rdata1_ex,
  output logic [DATA_W-1:0] rdata2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic              RegWrite_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              MemtoReg_ex,
  output logic              ALUSrc_ex,
  output logic              RegDst_ex,
  output logic [3:0]        ALUOp_ex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t              ctrl_q, ctrl_d, ctrl_id;
  logic               valid_q, valid_d;
  logic [REG_AW-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;

  id_ex_stage_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .mem_read_ex_i (ctrl_q.mem_read),
    .valid_ex_i    (valid_q),
    .rt_ex_i       (rt_q),
    .valid_id_i    (valid_id),
    .rs_id_i       (rs_id),
    .rt_id_i       (rt_id),
    .uses_rt_id_i  (uses_rt_id),
    .hold_i        (hold),
    .flush_i       (flush),
    .lu_o          (lu),
    .pc_write_o    (pc_write),
    .ifid_write_o  (ifid_write)
  );

  // Next-state selection: freeze, bubble, or capture the ID instruction
  always_comb begin
    ctrl_id  = valid_id ? ctrl_t'{reg_write:  RegWrite_id, mem_read: MemRead_id,
                                  mem_write:  MemWrite_id, mem_to_reg: MemtoReg_id,
                                  alu_src:    ALUSrc_id,   reg_dst: RegDst_id,
                                  alu_op:     ALUOp_id}
                        : CTRL_BUBBLE;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    cnt_d    = cnt_q;
    if (hold) begin
      // everything retains its value; flush and lu wait for the release
    end else if (flush || lu) begin
      ctrl_d   = CTRL_BUBBLE;
      valid_d  = 1'b0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      if (!flush && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    end else begin
      ctrl_d   = ctrl_id;
      valid_d  = valid_id;
      rs_d     = rs_id;
      rt_d     = rt_id;
      rd_d     = rd_id;
      rdata1_d = rdata1_id;
      rdata2_d = rdata2_id;
      imm_d    = imm_id;
    end
  end

  // Pipeline register and bubble counter, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= CTRL_BUBBLE;
      valid_q  <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_ex    = valid_q;
  assign rs_ex       = rs_q;
  assign rt_ex       = rt_q;
  assign rd_ex       = rd_q;
  assign rdata1_ex   = rdata1_q;
  assign rdata2_ex   = rdata2_q;
  assign imm_ex      = imm_q;
  assign RegWrite_ex = ctrl_q.reg_write;
  assign MemRead_ex  = ctrl_q.mem_read;
  assign MemWrite_ex = ctrl_q.mem_write;
  assign MemtoReg_ex = ctrl_q.mem_to_reg;
  assign ALUSrc_ex   = ctrl_q.alu_src;
  assign RegDst_ex   = ctrl_q.reg_dst;
  assign ALUOp_ex    = ctrl_q.alu_op;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps plus a short random tail, EX contents checked
// one cycle after drive against an expected queue built from a small reference model.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int W      = 1 + 3*REG_AW + 3*DATA_W + 6 + 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, hold, flush, valid_id, uses_rt_id;
  logic [REG_AW-1:0] rs_id, rt_id, rd_id;
  logic [DATA_W-1:0] rdata1_id, rdata2_id, imm_id;
  logic              RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id;
  logic [3:0]        ALUOp_id;
  logic              valid_ex;
  logic [REG_AW-1:0] rs_ex, rt_ex, rd_ex;
  logic [DATA_W-1:0] rdata1_ex, rdata2_ex, imm_ex;
  logic              RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, RegDst_ex;
  logic [3:0]        ALUOp_ex;
  logic              pc_write, ifid_write;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .valid_id(valid_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .uses_rt_id(uses_rt_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemtoReg_id(MemtoReg_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
    .ALUOp_id(ALUOp_id),
    .valid_ex(valid_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .ALUSrc_ex(ALUSrc_ex), .RegDst_ex(RegDst_ex),
    .ALUOp_ex(ALUOp_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {valid_ex, rs_ex, rt_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex,
                    RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex,
                    RegDst_ex, ALUOp_ex};

  // scoreboard
  logic [W-1:0]      exp_q[$];
  int                checks = 0;
  int                errors = 0;

  // reference model of EX state
  logic              m_valid = 1'b0;
  logic              m_memread = 1'b0;
  logic [REG_AW-1:0] m_rt = '0;
  logic [CNT_W-1:0]  m_cnt = '0;
  logic [W-1:0]      m_vec = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_id();
    logic [9:0] c;
    c = valid_id ? {RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id,
                    RegDst_id, ALUOp_id} : 10'd0;
    return {valid_id, rs_id, rt_id, rd_id, rdata1_id, rdata2_id, imm_id, c};
  endfunction

  // driver tasks
  task automatic set_id(input logic v, input int rs, input int rt, input int rd,
                        input logic urt, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic asrc, input logic rdst,
                        input logic [3:0] op);
    valid_id    = v;
    rs_id       = REG_AW'(rs);
    rt_id       = REG_AW'(rt);
    rd_id       = REG_AW'(rd);
    uses_rt_id  = urt;
    rdata1_id   = $urandom;
    rdata2_id   = $urandom;
    imm_id      = $urandom;
    RegWrite_id = rw;  MemRead_id = mr;  MemWrite_id = mw;
    MemtoReg_id = m2r; ALUSrc_id  = asrc; RegDst_id  = rdst;
    ALUOp_id    = op;
  endtask

  task automatic id_lw(input int rt, input int rs);
    set_id(1'b1, rs, rt, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
  endtask

  task automatic id_add(input int rd, input int rs, input int rt);
    set_id(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
  endtask

  task automatic id_addi(input int rt, input int rs);
    set_id(1'b1, rs, rt, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
  endtask

  task automatic id_nop();
    set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // One clock: check stall outputs, predict EX, clock, compare
  task automatic step(input logic r, input logic h, input logic f);
    logic lu_m, pc_m;
    logic [W-1:0] e;
    rst = r; hold = h; flush = f;
    #1;
    lu_m = m_memread & m_valid & (m_rt != 0) & valid_id &
           ((m_rt == rs_id) | (uses_rt_id & (m_rt == rt_id)));
    pc_m = ~h & ~(lu_m & ~f);
    if (!r) begin
      chk("pc_write", W'(pc_write), W'(pc_m));
      chk("ifid_write", W'(ifid_write), W'(pc_m));
    end
    if (r) begin
      m_vec = '0; m_valid = 1'b0; m_memread = 1'b0; m_rt = '0; m_cnt = '0;
    end else if (h) begin
      // frozen
    end else if (f || lu_m) begin
      m_vec = '0; m_valid = 1'b0; m_memread = 1'b0; m_rt = '0;
      if (!f && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_vec = pack_id(); m_valid = valid_id; m_memread = MemRead_id & valid_id; m_rt = rt_id;
    end
    exp_q.push_back(m_vec);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("ex_regs", dut_vec, e);
    chk("bubble_cnt", W'(bubble_cnt), W'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with busy ID inputs and hold/flush asserted: reset must win
    id_lw(5, 3);
    step(1'b1, 1'b1, 1'b1);
    id_add(6, 5, 7);
    step(1'b1, 1'b1, 1'b1);
    chk("reset_cnt", W'(bubble_cnt), W'(0));
    chk("reset_valid", W'(valid_ex), W'(0));

    // pass-through of add r3,r1,r2
    set_id(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    rdata1_id = 32'h10; rdata2_id = 32'h20;
    step(1'b0, 1'b0, 1'b0);
    chk("pass_rdata1", W'(rdata1_ex), W'(32'h10));
    chk("pass_rd", W'(rd_ex), W'(3));

    // load-use: lw r5 then add r6,r5,r1 -> one bubble, then add enters
    id_lw(5, 1);           step(1'b0, 1'b0, 1'b0);
    id_add(6, 5, 1);       step(1'b0, 1'b0, 1'b0);
    chk("lu_bubble_valid", W'(valid_ex), W'(0));
    chk("lu_bubble_rw", W'(RegWrite_ex), W'(0));
    step(1'b0, 1'b0, 1'b0);
    chk("lu_add_enters_rd", W'(rd_ex), W'(6));
    chk("lu_count", W'(bubble_cnt), W'(1));

    // lw r0 then a use of r0: no stall
    id_lw(0, 2);           step(1'b0, 1'b0, 1'b0);
    id_add(1, 0, 0);       step(1'b0, 1'b0, 1'b0);

    // lw r5 then addi r6,r7 with rt=5 but rt not a source: no stall
    id_lw(5, 2);           step(1'b0, 1'b0, 1'b0);
    id_addi(5, 7);         step(1'b0, 1'b0, 1'b0);

    // load-use coinciding with flush: flush wins, no count
    id_lw(5, 2);           step(1'b0, 1'b0, 1'b0);
    id_add(6, 5, 1);       step(1'b0, 1'b0, 1'b1);
    chk("flush_cnt", W'(bubble_cnt), W'(1));

    // hold for 3 cycles during a load-use, then the single bubble
    id_lw(5, 2);           step(1'b0, 1'b0, 1'b0);
    id_add(6, 1, 5);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("hold_frozen_rt", W'(rt_ex), W'(5));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("hold_count", W'(bubble_cnt), W'(2));

    // five more bubbles: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      id_lw(4, 1);         step(1'b0, 1'b0, 1'b0);
      id_add(2, 4, 3);     step(1'b0, 1'b0, 1'b0);
    end
    chk("sat_count", W'(bubble_cnt), W'(3));

    // random tail
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: id_lw($urandom_range(0, 7), $urandom_range(0, 7));
        1: id_add($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        2: id_addi($urandom_range(0, 7), $urandom_range(0, 7));
        default: id_nop();
      endcase
      step(1'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipelined CPU.
- Captures decoded operands, register specifiers and control from ID, and presents them to EX.
- Supplies rs_ex/rt_ex to the forwarding unit.
- Inserts a one-cycle bubble on a load-use hazard, squashes on branch flush, freezes on external hold, and counts inserted bubbles.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  external freeze (memory wait); ID/EX retains contents
- flush  in  1  squash instruction in ID (taken branch/jump)
- valid_id  in  1  ID holds a real instruction
- rs_id, rt_id, rd_id  in  REG_AW  register specifiers from decode
- uses_rt_id  in  1  ID instruction reads rt as a source (R-type, store, beq/bne)
- rdata1_id, rdata2_id  in  DATA_W  register file read data
- imm_id  in  DATA_W  sign-extended immediate
- RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id  in  1 each  control
- ALUOp_id  in  4  ALU operation code
- valid_ex  out  1  EX holds a real instruction
- rs_ex, rt_ex, rd_ex  out  REG_AW  registered specifiers
- rdata1_ex, rdata2_ex, imm_ex  out  DATA_W  registered data
- RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, RegDst_ex  out  1 each
- ALUOp_ex  out  4
- pc_write  out  1  PC may advance
- ifid_write  out  1  IF/ID register may load
- bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (rst=1 at edge): all *_ex outputs = 0, valid_ex = 0, bubble_cnt = 0. Reset overrides every other input.
- Hazard term (combinational), lu = MemRead_ex & valid_ex & (rt_ex != 0) & valid_id & ((rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id))).
- Stall outputs (combinational): pc_write = ifid_write = ~hold & ~(lu & ~flush).
- Per-edge update priority when rst=0:
  1. hold=1: all ID/EX registers and bubble_cnt retain their values; flush and lu are ignored that cycle.
  2. flush=1: load a bubble (all control = 0, valid_ex = 0, data/specifier fields = 0); bubble_cnt unchanged.
  3. lu=1: load a bubble as in step 2; bubble_cnt += 1, saturating at 2^CNT_W-1.
  4. Otherwise: load all ID fields; valid_ex = valid_id. If valid_id=0, all control fields load as 0.
- Bubble duration: a bubble clears MemRead_ex, so lu falls the next cycle. Exactly one bubble is inserted per load-use pair, and the stalled instruction then enters EX with forwarding from MEM.
- Register $0: rt_ex == 0 never raises lu.
- Latency: one cycle from ID inputs to *_ex outputs. No combinational path from ID data to *_ex outputs.
- Simultaneous lu and flush: flush wins, pc_write = 1, no count.
- hold asserted mid-bubble: the bubble persists until hold drops, and lu is re-evaluated afterwards against the unchanged EX contents.

Decomposition:
- Shared package: REG_AW, DATA_W, the ALUOp encodings, and a constant for the bubble (all-zero control bundle).
- Natural sub-module: hazard_detect, holding the combinational lu, pc_write and ifid_write logic. The register bank and counter stay in id_ex_stage.

Test Plan:
- Reset with all ID inputs nonzero, rst=1 for 2 cycles -> every *_ex = 0, bubble_cnt = 0, pc_write = 1.
- Pass-through: ID presents add r3,r1,r2 (rs=1, rt=2, rd=3, RegWrite=1, ALUOp=2, rdata1=0x10, rdata2=0x20) -> next cycle rs_ex=1, rt_ex=2, rd_ex=3, rdata1_ex=0x10, RegWrite_ex=1, valid_ex=1.
- Load-use: lw r5 in EX (MemRead_ex=1, rt_ex=5), then add r6,r5,r1 in ID -> pc_write = ifid_write = 0 for exactly 1 cycle; next cycle EX is a bubble (RegWrite_ex=0, valid_ex=0); the add then enters EX; bubble_cnt = 1.
- No hazard cases:
  - lw r0 followed by a use of r0 -> no stall.
  - lw r5 followed by addi r6,r7 with uses_rt_id=0 and rt_id=5 -> no stall.
- Flush versus hazard: the load-use condition and flush=1 in the same cycle -> pc_write = 1, EX gets a bubble, bubble_cnt unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles during a load-use -> EX contents frozen, pc_write = 0; the single bubble follows the release.
  - With CNT_W=2, 5 consecutive bubbles -> bubble_cnt stops at 3.
